// File: rtl/im_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Loader FSM encodings and header-format constants.
package im_loader_pkg;

    typedef enum logic [2:0] {
        LD_CNT_HI,
        LD_CNT_LO,
        LD_CHECK,
        LD_DATA,
        LD_FLUSH,
        LD_DONE,
        LD_ERR
    } ld_state_t;

    localparam int LD_HDR_BYTES = 2;
    localparam int LD_CNT_W     = 8 * LD_HDR_BYTES;

    // Word count from the header converted to an IM byte count.
    function automatic logic [17:0] words_to_bytes(input logic [LD_CNT_W-1:0] words);
        return {words, 2'b00};
    endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
// The source owns in_valid/in_data; the loader owns in_ready.
interface im_loader_if;
    import im_loader_pkg::*;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/im_loader.sv
// Boot loader: takes a big-endian word count plus instruction words from a byte
// stream, writes them into byte-addressed IM, and holds the CPU in reset until done.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int IM_BYTES = 1024,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    im_loader_if.slave        s,
    input  logic              reload,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [7:0]        im_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam logic [17:0] CAP = 18'(IM_BYTES);

    ld_state_t           state;
    logic [LD_CNT_W-1:0] cnt;
    logic [ADDR_W-1:0]   addr;
    logic [17:0]         bytes_left;
    logic                accept;

    assign accept = s.in_valid && s.in_ready;

    // Single FSM; every output is a register so IM and the CPU see clean edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LD_CNT_HI;
            s.in_ready <= 1'b0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            cnt        <= '0;
            addr       <= '0;
            bytes_left <= '0;
        end else begin
            im_we <= 1'b0;
            case (state)
                LD_CNT_HI: begin
                    s.in_ready <= 1'b1;
                    if (accept) begin
                        cnt[15:8] <= s.in_data;
                        state     <= LD_CNT_LO;
                    end
                end
                LD_CNT_LO: begin
                    if (accept) begin
                        cnt[7:0]   <= s.in_data;
                        s.in_ready <= 1'b0;
                        state      <= LD_CHECK;
                    end
                end
                LD_CHECK: begin
                    if (cnt == '0) begin
                        cpu_rst <= 1'b0;
                        done    <= 1'b1;
                        state   <= LD_DONE;
                    end else if (words_to_bytes(cnt) > CAP) begin
                        err   <= 1'b1;
                        state <= LD_ERR;
                    end else begin
                        bytes_left <= words_to_bytes(cnt);
                        addr       <= '0;
                        s.in_ready <= 1'b1;
                        state      <= LD_DATA;
                    end
                end
                LD_DATA: begin
                    if (accept) begin
                        im_we      <= 1'b1;
                        im_addr    <= addr;
                        im_wdata   <= s.in_data;
                        addr       <= addr + 1'b1;
                        bytes_left <= bytes_left - 18'd1;
                        if (bytes_left == 18'd1) begin
                            s.in_ready <= 1'b0;
                            state      <= LD_FLUSH;
                        end
                    end
                end
                // Last write is on the bus now; release the CPU right behind it.
                LD_FLUSH: begin
                    cpu_rst <= 1'b0;
                    done    <= 1'b1;
                    state   <= LD_DONE;
                end
                LD_DONE: begin
                    if (reload) begin
                        cpu_rst    <= 1'b1;
                        done       <= 1'b0;
                        s.in_ready <= 1'b1;
                        state      <= LD_CNT_HI;
                    end
                end
                LD_ERR: begin
                    s.in_ready <= 1'b0;
                end
                default: begin
                    state <= LD_CNT_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed self-checking bench for im_loader: header parsing, backpressure,
// zero/overflow/exact-fill counts, reset mid-load and reload.
module tb_im_loader;

    localparam int IM_BYTES = 1024;
    localparam int ADDR_W   = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              reload = 1'b0;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [7:0]        im_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    im_loader_if sif ();

    im_loader #(.IM_BYTES(IM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .s        (sif.slave),
        .reload   (reload),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]        im_model [0:IM_BYTES-1];
    int                cyc = 0;
    int                wr_count = 0;
    int                bad_we = 0;
    int                addr_bad = 0;
    int                first_wr_cyc = 0;
    int                last_wr_cyc = 0;
    int                fall_cyc = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic              prev_acc = 1'b0;
    logic              prev_cpu_rst = 1'b1;

    // IM model plus write-ordering and cpu_rst-release observation.
    always @(negedge clk) begin
        cyc++;
        if (im_we) begin
            if (!prev_acc) bad_we++;
            if (im_addr != ADDR_W'(wr_count)) addr_bad++;
            im_model[im_addr] = im_wdata;
            if (wr_count == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            last_addr   = im_addr;
            wr_count++;
        end
        if (prev_cpu_rst && !cpu_rst) fall_cyc = cyc;
        prev_cpu_rst = cpu_rst;
        prev_acc     = sif.in_valid && sif.in_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one byte and returns just after the edge that accepted it.
    task automatic applyStimulus(input logic [7:0] b);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        sif.in_valid = 1'b1;
        sif.in_data  = b;
        while (!acc && n < 50) begin
            acc = sif.in_ready;
            tick();
            n++;
        end
        if (!acc) checkOutput("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        checkOutput("done_wait", 32'(done), 32'd1);
    endtask

    task automatic clearMonitor();
        wr_count     = 0;
        bad_we       = 0;
        addr_bad     = 0;
        first_wr_cyc = 0;
        last_wr_cyc  = 0;
        fall_cyc     = 0;
    endtask

    task automatic pulseReload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    initial begin
        logic [7:0] bp_bytes [0:7];
        sif.in_valid = 1'b0;
        sif.in_data  = 8'h00;
        bp_bytes = '{8'h3c, 8'h0a, 8'h12, 8'h34, 8'h08, 8'h00, 8'h0c, 8'h08};

        // Reset state
        tick(); tick(); tick();
        checkOutput("rst_in_ready", 32'(sif.in_ready), 32'd0);
        checkOutput("rst_im_we",    32'(im_we),        32'd0);
        checkOutput("rst_im_addr",  32'(im_addr),      32'd0);
        checkOutput("rst_im_wdata", 32'(im_wdata),     32'd0);
        checkOutput("rst_cpu_rst",  32'(cpu_rst),      32'd1);
        checkOutput("rst_done",     32'(done),         32'd0);
        checkOutput("rst_err",      32'(err),          32'd0);
        rst = 1'b0;
        tick();
        checkOutput("ready_after_rst", 32'(sif.in_ready), 32'd1);

        // Single word 0x01095021 (addu $10,$8,$9), valid held high
        clearMonitor();
        applyStimulus(8'h00); applyStimulus(8'h01);
        applyStimulus(8'h01); applyStimulus(8'h09);
        applyStimulus(8'h50); applyStimulus(8'h21);
        sif.in_valid = 1'b0;
        checkOutput("sw_flush_cpu_rst", 32'(cpu_rst), 32'd1);
        tick();
        checkOutput("sw_done",    32'(done),    32'd1);
        checkOutput("sw_cpu_rst", 32'(cpu_rst), 32'd0);
        tick();
        checkOutput("sw_writes",   32'(wr_count), 32'd4);
        checkOutput("sw_consec",   32'(last_wr_cyc - first_wr_cyc), 32'd3);
        checkOutput("sw_release",  32'(fall_cyc), 32'(last_wr_cyc + 1));
        checkOutput("sw_word", {im_model[0], im_model[1], im_model[2], im_model[3]}, 32'h01095021);
        checkOutput("sw_addr_seq", 32'(addr_bad), 32'd0);

        pulseReload();
        checkOutput("rl_cpu_rst",  32'(cpu_rst),      32'd1);
        checkOutput("rl_done",     32'(done),         32'd0);
        checkOutput("rl_in_ready", 32'(sif.in_ready), 32'd1);

        // Backpressure: idle cycle after every byte
        clearMonitor();
        applyStimulus(8'h00); sif.in_valid = 1'b0; tick();
        applyStimulus(8'h02); sif.in_valid = 1'b0; tick();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(bp_bytes[i]);
            sif.in_valid = 1'b0;
            tick();
        end
        waitDone(20);
        tick();
        checkOutput("bp_writes",   32'(wr_count), 32'd8);
        checkOutput("bp_gap_we",   32'(bad_we),   32'd0);
        checkOutput("bp_addr_seq", 32'(addr_bad), 32'd0);
        checkOutput("bp_last_addr", 32'(last_addr), 32'd7);
        checkOutput("bp_word0", {im_model[0], im_model[1], im_model[2], im_model[3]}, 32'h3c0a1234);
        checkOutput("bp_word1", {im_model[4], im_model[5], im_model[6], im_model[7]}, 32'h08000c08);

        // Zero count
        pulseReload();
        clearMonitor();
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        sif.in_valid = 1'b0;
        checkOutput("zc_done_early", 32'(done), 32'd0);
        tick();
        checkOutput("zc_done",    32'(done),    32'd1);
        checkOutput("zc_cpu_rst", 32'(cpu_rst), 32'd0);
        tick();
        checkOutput("zc_writes",  32'(wr_count), 32'd0);

        // Overflow: 257 words
        pulseReload();
        clearMonitor();
        applyStimulus(8'h01);
        applyStimulus(8'h01);
        sif.in_valid = 1'b0;
        tick();
        checkOutput("ov_err",      32'(err),          32'd1);
        checkOutput("ov_in_ready", 32'(sif.in_ready), 32'd0);
        checkOutput("ov_cpu_rst",  32'(cpu_rst),      32'd1);
        checkOutput("ov_done",     32'(done),         32'd0);
        pulseReload();
        tick();
        checkOutput("ov_reload_err",   32'(err),          32'd1);
        checkOutput("ov_reload_ready", 32'(sif.in_ready), 32'd0);
        checkOutput("ov_writes",       32'(wr_count),     32'd0);
        rst = 1'b1;
        tick();
        checkOutput("ov_rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("ov_rst_ready", 32'(sif.in_ready), 32'd1);

        // Exact fill: 256 words
        clearMonitor();
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        for (int i = 0; i < IM_BYTES; i++) begin
            applyStimulus(8'(i * 7 + 3));
        end
        sif.in_valid = 1'b0;
        waitDone(10);
        tick();
        checkOutput("fill_writes",    32'(wr_count),  32'd1024);
        checkOutput("fill_last_addr", 32'(last_addr), 32'h3ff);
        checkOutput("fill_addr_seq",  32'(addr_bad),  32'd0);
        checkOutput("fill_err",       32'(err),       32'd0);
        checkOutput("fill_first",     32'(im_model[0]),     32'h03);
        checkOutput("fill_last",      32'(im_model[1023]),  32'hfc);

        // Reset mid-load after 3 data bytes
        pulseReload();
        clearMonitor();
        applyStimulus(8'h00); applyStimulus(8'h01);
        applyStimulus(8'haa); applyStimulus(8'hbb); applyStimulus(8'hcc);
        sif.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        checkOutput("mid_in_ready", 32'(sif.in_ready), 32'd0);
        checkOutput("mid_im_we",    32'(im_we),        32'd0);
        checkOutput("mid_cpu_rst",  32'(cpu_rst),      32'd1);
        rst = 1'b0;
        tick();
        clearMonitor();
        applyStimulus(8'h00); applyStimulus(8'h01);
        applyStimulus(8'hde); applyStimulus(8'had);
        applyStimulus(8'hbe); applyStimulus(8'hef);
        sif.in_valid = 1'b0;
        waitDone(10);
        tick();
        checkOutput("mid_writes",   32'(wr_count), 32'd4);
        checkOutput("mid_addr_seq", 32'(addr_bad), 32'd0);
        checkOutput("mid_word", {im_model[0], im_model[1], im_model[2], im_model[3]}, 32'hdeadbeef);
        pulseReload();
        checkOutput("mid_rl_cpu_rst",  32'(cpu_rst),      32'd1);
        checkOutput("mid_rl_done",     32'(done),         32'd0);
        checkOutput("mid_rl_in_ready", 32'(sif.in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
